button_conditioner: RTL and testbench
=====================================

BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 Parameter: DEBOUNCE_CYCLES, 1000000, cycles a synchronized input must stay stable before it is accepted (20 ms at 50 MHz).
REQ-002 Parameter: LONG_PRESS_CYCLES, 50000000, cycles held after accepted press before long_o fires.
REQ-003 Parameter: REPEAT_CYCLES, 10000000, auto-repeat period after long press.
REQ-004 Port: clk_clk  input  1  single system clock, rising edge.
REQ-005 Port: reset_reset_n  input  1  asynchronous, active-low reset.
REQ-006 Port: key_n_i  input  4  raw board pushbuttons, active-low, asynchronous to clk_clk.
REQ-007 Port: btn_level_o  output  4  debounced level, active-high, drives system buttons_external_connection_export.
REQ-008 Port: press_o  output  4  one-cycle pulse per accepted press.
REQ-009 Port: release_o  output  4  one-cycle pulse per accepted release.
REQ-010 Port: long_o  output  4  one-cycle pulse at long-press threshold.
REQ-011 Port: repeat_o  output  4  one-cycle auto-repeat pulses (see Configuration).

Function
REQ-012 Each key_n_i bit SHALL pass a 2-flop synchronizer, then be inverted; channels are fully independent.
REQ-013 Per-channel FSM states SHALL be IDLE, PRESS_WAIT, HELD, RELEASE_WAIT.
REQ-014 IDLE: synchronized input high -> PRESS_WAIT, counter cleared.
REQ-015 PRESS_WAIT: input returns low before count reaches DEBOUNCE_CYCLES -> IDLE, no pulse; count reaches DEBOUNCE_CYCLES -> HELD, press_o high for exactly one cycle, btn_level_o set same cycle.
REQ-016 HELD: hold counter increments each cycle; reaching LONG_PRESS_CYCLES -> long_o one-cycle pulse, once per press; counter then saturates (no wrap).
REQ-017 HELD: input low -> RELEASE_WAIT, debounce counter cleared.
REQ-018 RELEASE_WAIT: input high before DEBOUNCE_CYCLES -> HELD with hold counter preserved (bounce does not restart long-press timing); count reaches DEBOUNCE_CYCLES -> IDLE, release_o one-cycle pulse, btn_level_o cleared same cycle.
REQ-019 Latency pin-to-press_o SHALL be 2 synchronizer cycles + DEBOUNCE_CYCLES + 1 registered cycle.
REQ-020 All outputs SHALL be registered; press_o and release_o of one channel never high together.
REQ-021 Counter widths SHALL be $clog2 of the largest parameter + 1; counters saturate, never wrap.
REQ-022 Simultaneous events across channels SHALL each produce their own pulses in the same cycle.

Reset
REQ-023 reset_reset_n low SHALL asynchronously force all FSMs to IDLE, counters and synchronizer flops to 0, all outputs to 0.
REQ-024 A key held through reset release SHALL be treated as a fresh press (full debounce, then press_o).
REQ-025 Reset asserted mid-press SHALL suppress any pending release_o/long_o pulse.

Configuration
REQ-026 Macro BUTTON_AUTOREPEAT_EN defined: after long_o, repeat_o pulses one cycle every REPEAT_CYCLES while in HELD or RELEASE_WAIT; repeat timer restarts on each new press.
REQ-027 Macro undefined: repeat logic absent, repeat_o tied to 0.

Structure
REQ-028 Shared package button_pkg SHALL hold the FSM state enum, NUM_BUTTONS = 4, and the counter-width function.
REQ-029 Sub-module button_channel SHALL implement one synchronizer + FSM + counters; top instantiates four via generate.

Verification (DEBOUNCE_CYCLES=8, LONG_PRESS_CYCLES=32, REPEAT_CYCLES=8)
REQ-030 key_n_i[0] low at cycle 0, held 20 cycles -> press_o[0] pulse at cycle 11, btn_level_o[0]=1 from cycle 11.
REQ-031 key_n_i[1] low for 5 cycles, then 3-cycle high glitches, repeated 4 times -> no press_o[1], btn_level_o[1] stays 0.
REQ-032 key_n_i[2] held 60 cycles -> press_o[2] once, long_o[2] once 32 cycles after press, release_o[2] 11 cycles after key released.
REQ-033 With BUTTON_AUTOREPEAT_EN, key_n_i[3] held 64 cycles after press -> repeat_o[3] pulses at long+8, +16, +24, +32; without macro repeat_o stays 0.
REQ-034 All four keys pressed same cycle -> press_o=4'hF in one cycle; reset asserted 3 cycles later -> all outputs 0 immediately, no release_o after deassert while keys stay up.

Source files
------------

// File: rtl/button_pkg.sv
// -----------------------------------------------------------------------------
// button_pkg
// Shared definitions for the pushbutton conditioner: channel count, the
// per-channel FSM state encoding and the counter-width helper.
// -----------------------------------------------------------------------------
package button_pkg;

   localparam int NUM_BUTTONS = 4;

   typedef enum logic [1:0] {
      IDLE         = 2'd0,
      PRESS_WAIT   = 2'd1,
      HELD         = 2'd2,
      RELEASE_WAIT = 2'd3
   } btn_state_t;

   // Width able to hold the largest timing parameter with one bit of headroom.
   function automatic int cnt_width(input int a, input int b, input int c);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      return $clog2(m) + 1;
   endfunction

endpackage

// File: rtl/button_conditioner_if.sv
// -----------------------------------------------------------------------------
// button_conditioner_if
// Groups the raw key inputs and the conditioned event outputs.
//   key_n_i     : raw active-low pushbuttons (asynchronous)
//   btn_level_o : debounced active-high level
//   press_o     : one-cycle pulse per accepted press
//   release_o   : one-cycle pulse per accepted release
//   long_o      : one-cycle pulse at the long-press threshold
//   repeat_o    : one-cycle auto-repeat pulses
// master drives the keys (board side), slave is the conditioner.
// -----------------------------------------------------------------------------
interface button_conditioner_if;

   logic [button_pkg::NUM_BUTTONS-1:0] key_n_i;
   logic [button_pkg::NUM_BUTTONS-1:0] btn_level_o;
   logic [button_pkg::NUM_BUTTONS-1:0] press_o;
   logic [button_pkg::NUM_BUTTONS-1:0] release_o;
   logic [button_pkg::NUM_BUTTONS-1:0] long_o;
   logic [button_pkg::NUM_BUTTONS-1:0] repeat_o;

   modport master (
      output key_n_i,
      input  btn_level_o, press_o, release_o, long_o, repeat_o
   );

   modport slave (
      input  key_n_i,
      output btn_level_o, press_o, release_o, long_o, repeat_o
   );

endinterface

// File: rtl/button_channel.sv
// -----------------------------------------------------------------------------
// button_channel
// One pushbutton: 2-flop synchronizer, debounce/hold FSM and its counters.
// Build option: BUTTON_AUTOREPEAT_EN enables the auto-repeat timer; without it
// o_repeat is tied low.
// Ports:
//   clk_clk, reset_reset_n : clock, asynchronous active-low reset
//   i_key_n                : raw active-low key
//   o_level                : debounced level (registered)
//   o_press/o_release      : accepted press/release pulses (registered)
//   o_long/o_repeat        : long-press and auto-repeat pulses (registered)
// -----------------------------------------------------------------------------
module button_channel
   import button_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES   = 1000000,
   parameter int LONG_PRESS_CYCLES = 50000000,
   parameter int REPEAT_CYCLES     = 10000000
) (
   input  logic clk_clk,
   input  logic reset_reset_n,
   input  logic i_key_n,
   output logic o_level,
   output logic o_press,
   output logic o_release,
   output logic o_long,
   output logic o_repeat
);

   localparam int CW = cnt_width(DEBOUNCE_CYCLES, LONG_PRESS_CYCLES, REPEAT_CYCLES);
   localparam logic [CW-1:0] DEB_MAX   = CW'(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] LONG_MAX  = CW'(LONG_PRESS_CYCLES);
   localparam logic [CW-1:0] LONG_LAST = CW'(LONG_PRESS_CYCLES - 1);

   logic       r_sync1, r_sync2;
   logic       w_active;
   btn_state_t r_state, w_state_nxt;
   logic [CW-1:0] r_deb_cnt, r_hold_cnt;
   logic w_level, w_press, w_release, w_long, w_repeat;
   logic r_level, r_press, r_release, r_long, r_repeat;

   // The synchronizer carries the raw active-low key; inversion follows it.
   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
      end else begin
         r_sync1 <= i_key_n;
         r_sync2 <= r_sync1;
      end
   end

   assign w_active = ~r_sync2;

   // State register
   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) r_state <= IDLE;
      else                r_state <= w_state_nxt;
   end

   // Next-state logic
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE: begin
            if (w_active) w_state_nxt = PRESS_WAIT;
         end
         PRESS_WAIT: begin
            if (!w_active)                 w_state_nxt = IDLE;
            else if (r_deb_cnt >= DEB_MAX) w_state_nxt = HELD;
         end
         HELD: begin
            if (!w_active) w_state_nxt = RELEASE_WAIT;
         end
         RELEASE_WAIT: begin
            if (w_active)                  w_state_nxt = HELD;
            else if (r_deb_cnt >= DEB_MAX) w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // Output decode; every event is registered below so it lines up with the
   // state it announces.
   always_comb begin
      w_level   = (w_state_nxt == HELD) || (w_state_nxt == RELEASE_WAIT);
      w_press   = (r_state == PRESS_WAIT)   && (w_state_nxt == HELD);
      w_release = (r_state == RELEASE_WAIT) && (w_state_nxt == IDLE);
      // The hold counter passes LONG_LAST exactly once per press because it
      // saturates at LONG_MAX.
      w_long    = (r_state == HELD) && (r_hold_cnt == LONG_LAST);
   end

   // Debounce counter restarts on every state change, so it measures how long
   // the synchronized input has been stable in the current wait state.
   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         r_deb_cnt <= '0;
      end else if (w_state_nxt != r_state) begin
         r_deb_cnt <= '0;
      end else if (((r_state == PRESS_WAIT) || (r_state == RELEASE_WAIT)) &&
                   (r_deb_cnt < DEB_MAX)) begin
         r_deb_cnt <= r_deb_cnt + CW'(1);
      end
   end

   // Hold counter only advances in HELD; release bounces freeze it rather
   // than restart it.
   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         r_hold_cnt <= '0;
      end else if ((r_state == PRESS_WAIT) && (w_state_nxt == HELD)) begin
         r_hold_cnt <= '0;
      end else if ((r_state == HELD) && (r_hold_cnt < LONG_MAX)) begin
         r_hold_cnt <= r_hold_cnt + CW'(1);
      end
   end

`ifdef BUTTON_AUTOREPEAT_EN
   localparam logic [CW-1:0] RPT_LAST = CW'(REPEAT_CYCLES - 1);

   logic [CW-1:0] r_rep_cnt;
   logic          w_rep_run;

   // Repeat runs once the long press has fired (hold counter saturated) and
   // the key is still considered down.
   assign w_rep_run = ((r_state == HELD) || (r_state == RELEASE_WAIT)) &&
                      (r_hold_cnt == LONG_MAX);

   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         r_rep_cnt <= '0;
      end else if ((r_state == PRESS_WAIT) && (w_state_nxt == HELD)) begin
         r_rep_cnt <= '0;
      end else if (w_rep_run) begin
         if (r_rep_cnt == RPT_LAST) r_rep_cnt <= '0;
         else                       r_rep_cnt <= r_rep_cnt + CW'(1);
      end
   end

   assign w_repeat = w_rep_run && (r_rep_cnt == RPT_LAST);
`else
   assign w_repeat = 1'b0;
`endif

   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         r_level   <= 1'b0;
         r_press   <= 1'b0;
         r_release <= 1'b0;
         r_long    <= 1'b0;
         r_repeat  <= 1'b0;
      end else begin
         r_level   <= w_level;
         r_press   <= w_press;
         r_release <= w_release;
         r_long    <= w_long;
         r_repeat  <= w_repeat;
      end
   end

   assign o_level   = r_level;
   assign o_press   = r_press;
   assign o_release = r_release;
   assign o_long    = r_long;
   assign o_repeat  = r_repeat;

endmodule

// File: rtl/button_conditioner.sv
// -----------------------------------------------------------------------------
// button_conditioner
// Four independent pushbutton channels: synchronize, debounce, and generate
// press / release / long-press / auto-repeat events.
// Build option: define BUTTON_AUTOREPEAT_EN to enable auto-repeat pulses;
// otherwise repeat_o stays 0.
// Ports:
//   clk_clk       : system clock, rising edge
//   reset_reset_n : asynchronous active-low reset
//   bus (slave)   : key_n_i in; btn_level_o, press_o, release_o, long_o,
//                   repeat_o out (all outputs registered)
// -----------------------------------------------------------------------------
module button_conditioner
   import button_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES   = 1000000,
   parameter int LONG_PRESS_CYCLES = 50000000,
   parameter int REPEAT_CYCLES     = 10000000
) (
   input  logic                 clk_clk,
   input  logic                 reset_reset_n,
   button_conditioner_if.slave  bus
);

   logic [NUM_BUTTONS-1:0] w_level, w_press, w_release, w_long, w_repeat;

   for (genvar g = 0; g < NUM_BUTTONS; g++) begin : g_chan
      button_channel #(
         .DEBOUNCE_CYCLES   (DEBOUNCE_CYCLES),
         .LONG_PRESS_CYCLES (LONG_PRESS_CYCLES),
         .REPEAT_CYCLES     (REPEAT_CYCLES)
      ) u_chan (
         .clk_clk       (clk_clk),
         .reset_reset_n (reset_reset_n),
         .i_key_n       (bus.key_n_i[g]),
         .o_level       (w_level[g]),
         .o_press       (w_press[g]),
         .o_release     (w_release[g]),
         .o_long        (w_long[g]),
         .o_repeat      (w_repeat[g])
      );
   end

   assign bus.btn_level_o = w_level;
   assign bus.press_o     = w_press;
   assign bus.release_o   = w_release;
   assign bus.long_o      = w_long;
   assign bus.repeat_o    = w_repeat;

endmodule

// File: tb/tb_button_conditioner.sv
// -----------------------------------------------------------------------------
// tb_button_conditioner
// Bench for button_conditioner with DEBOUNCE=8, LONG=32, REPEAT=8.
// Keys change on the falling edge; a key change at falling edge with cycle
// count c is first sampled at rising edge c+1, and press/release pulses are
// visible at the falling edge with count c+12 (2 sync + 8 debounce + 1).
// Expected pulse events are queued as stimulus is applied and checked in
// arrival order by a monitor running on every falling edge.
// -----------------------------------------------------------------------------
module tb_button_conditioner;

   localparam int KIND_PRESS   = 0;
   localparam int KIND_RELEASE = 1;
   localparam int KIND_LONG    = 2;
   localparam int KIND_REPEAT  = 3;

   typedef struct packed {
      int cyc;
      int ch;
      int kind;
   } ev_t;

   logic clk = 1'b0;
   logic rst_n;
   int   cyc = 0;
   int   n_cmp = 0;
   int   n_err = 0;
   ev_t  sb[$];

   button_conditioner_if bus();

   button_conditioner #(
      .DEBOUNCE_CYCLES   (8),
      .LONG_PRESS_CYCLES (32),
      .REPEAT_CYCLES     (8)
   ) dut (
      .clk_clk       (clk),
      .reset_reset_n (rst_n),
      .bus           (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic ev_t mk(input int c, input int ch, input int kind);
      ev_t e;
      e.cyc  = c;
      e.ch   = ch;
      e.kind = kind;
      return e;
   endfunction

   task automatic monitor();
      logic [3:0] pl [4];
      ev_t e;
      forever begin
         @(negedge clk);
         while (sb.size() > 0 && sb[0].cyc < cyc) begin
            e = sb.pop_front();
            n_cmp++;
            n_err++;
            $display("FAIL event_missing: kind=%0d ch=%0d never seen, required at cycle %0d (now %0d)",
                     e.kind, e.ch, e.cyc, cyc);
         end
         pl[0] = bus.press_o;
         pl[1] = bus.release_o;
         pl[2] = bus.long_o;
         pl[3] = bus.repeat_o;
         for (int k = 0; k < 4; k++) begin
            for (int ch = 0; ch < 4; ch++) begin
               if (pl[k][ch] === 1'b1) begin
                  n_cmp++;
                  if (sb.size() == 0) begin
                     n_err++;
                     $display("FAIL event_unexpected: got kind=%0d ch=%0d at cycle %0d, required no event",
                              k, ch, cyc);
                  end else begin
                     e = sb.pop_front();
                     if (e.cyc !== cyc || e.ch !== ch || e.kind !== k) begin
                        n_err++;
                        $display("FAIL event_match: got kind=%0d ch=%0d cycle=%0d, required kind=%0d ch=%0d cycle=%0d",
                                 k, ch, cyc, e.kind, e.ch, e.cyc);
                     end
                  end
               end
            end
         end
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      bus.key_n_i = 4'hF;
      repeat (3) @(negedge clk);
      n_cmp++;
      if (bus.btn_level_o !== 4'h0) begin
         n_err++; $display("FAIL reset_level: got %h, required 0", bus.btn_level_o);
      end
      n_cmp++;
      if (bus.press_o !== 4'h0) begin
         n_err++; $display("FAIL reset_press: got %h, required 0", bus.press_o);
      end
      n_cmp++;
      if (bus.release_o !== 4'h0) begin
         n_err++; $display("FAIL reset_release: got %h, required 0", bus.release_o);
      end
      n_cmp++;
      if (bus.long_o !== 4'h0) begin
         n_err++; $display("FAIL reset_long: got %h, required 0", bus.long_o);
      end
      n_cmp++;
      if (bus.repeat_o !== 4'h0) begin
         n_err++; $display("FAIL reset_repeat: got %h, required 0", bus.repeat_o);
      end
      rst_n = 1'b1;
      repeat (20) @(negedge clk);
      n_cmp++;
      if (bus.btn_level_o !== 4'h0) begin
         n_err++; $display("FAIL reset_idle_level: got %h, required 0", bus.btn_level_o);
      end
      n_cmp++;
      if (sb.size() !== 0) begin
         n_err++; $display("FAIL reset_queue: got %0d pending, required 0", sb.size());
      end
   endtask

   task automatic test_press();
      int c;
      c = cyc;
      bus.key_n_i[0] = 1'b0;
      sb.push_back(mk(c + 12, 0, KIND_PRESS));
      repeat (11) @(negedge clk);
      n_cmp++;
      if (bus.btn_level_o[0] !== 1'b0) begin
         n_err++; $display("FAIL press_level_early: got %b, required 0", bus.btn_level_o[0]);
      end
      @(negedge clk);
      n_cmp++;
      if (bus.btn_level_o[0] !== 1'b1) begin
         n_err++; $display("FAIL press_level_set: got %b, required 1", bus.btn_level_o[0]);
      end
      n_cmp++;
      if ((bus.press_o & bus.release_o) !== 4'h0) begin
         n_err++; $display("FAIL press_release_overlap: got %h, required 0", bus.press_o & bus.release_o);
      end
      repeat (8) @(negedge clk);
      bus.key_n_i[0] = 1'b1;
      sb.push_back(mk(c + 32, 0, KIND_RELEASE));
      repeat (11) @(negedge clk);
      n_cmp++;
      if (bus.btn_level_o[0] !== 1'b1) begin
         n_err++; $display("FAIL release_level_early: got %b, required 1", bus.btn_level_o[0]);
      end
      @(negedge clk);
      n_cmp++;
      if (bus.btn_level_o[0] !== 1'b0) begin
         n_err++; $display("FAIL release_level_clear: got %b, required 0", bus.btn_level_o[0]);
      end
      repeat (5) @(negedge clk);
      n_cmp++;
      if (sb.size() !== 0) begin
         n_err++; $display("FAIL press_queue: got %0d pending, required 0", sb.size());
      end
   endtask

   task automatic test_glitch();
      for (int r = 0; r < 4; r++) begin
         bus.key_n_i[1] = 1'b0;
         repeat (5) begin
            @(negedge clk);
            n_cmp++;
            if ({bus.btn_level_o[1], bus.press_o[1]} !== 2'b00) begin
               n_err++; $display("FAIL glitch_low: got level/press %b%b, required 00",
                                 bus.btn_level_o[1], bus.press_o[1]);
            end
         end
         bus.key_n_i[1] = 1'b1;
         repeat (3) begin
            @(negedge clk);
            n_cmp++;
            if ({bus.btn_level_o[1], bus.press_o[1]} !== 2'b00) begin
               n_err++; $display("FAIL glitch_high: got level/press %b%b, required 00",
                                 bus.btn_level_o[1], bus.press_o[1]);
            end
         end
      end
      repeat (12) @(negedge clk);
      n_cmp++;
      if (sb.size() !== 0) begin
         n_err++; $display("FAIL glitch_queue: got %0d pending, required 0", sb.size());
      end
   endtask

   task automatic test_long();
      int c;
      c = cyc;
      bus.key_n_i[2] = 1'b0;
      sb.push_back(mk(c + 12, 2, KIND_PRESS));
      sb.push_back(mk(c + 44, 2, KIND_LONG));
`ifdef BUTTON_AUTOREPEAT_EN
      sb.push_back(mk(c + 52, 2, KIND_REPEAT));
      sb.push_back(mk(c + 60, 2, KIND_REPEAT));
      sb.push_back(mk(c + 68, 2, KIND_REPEAT));
`endif
      repeat (60) @(negedge clk);
      n_cmp++;
      if (bus.btn_level_o[2] !== 1'b1) begin
         n_err++; $display("FAIL long_level_held: got %b, required 1", bus.btn_level_o[2]);
      end
      bus.key_n_i[2] = 1'b1;
      sb.push_back(mk(c + 72, 2, KIND_RELEASE));
      repeat (12) @(negedge clk);
      n_cmp++;
      if (bus.btn_level_o[2] !== 1'b0) begin
         n_err++; $display("FAIL long_level_released: got %b, required 0", bus.btn_level_o[2]);
      end
      repeat (10) @(negedge clk);
      n_cmp++;
      if (sb.size() !== 0) begin
         n_err++; $display("FAIL long_queue: got %0d pending, required 0", sb.size());
      end
   endtask

   task automatic test_repeat();
      int c;
      c = cyc;
      bus.key_n_i[3] = 1'b0;
      sb.push_back(mk(c + 12, 3, KIND_PRESS));
      sb.push_back(mk(c + 44, 3, KIND_LONG));
`ifdef BUTTON_AUTOREPEAT_EN
      // Repeats continue through the release debounce window.
      for (int k = 1; k <= 5; k++) sb.push_back(mk(c + 44 + 8 * k, 3, KIND_REPEAT));
`endif
      repeat (76) @(negedge clk);
      bus.key_n_i[3] = 1'b1;
      sb.push_back(mk(c + 88, 3, KIND_RELEASE));
      repeat (11) @(negedge clk);
      n_cmp++;
      if (bus.btn_level_o[3] !== 1'b1) begin
         n_err++; $display("FAIL repeat_level_held: got %b, required 1", bus.btn_level_o[3]);
      end
      @(negedge clk);
      n_cmp++;
      if (bus.btn_level_o[3] !== 1'b0) begin
         n_err++; $display("FAIL repeat_level_released: got %b, required 0", bus.btn_level_o[3]);
      end
      repeat (12) @(negedge clk);
      n_cmp++;
      if (sb.size() !== 0) begin
         n_err++; $display("FAIL repeat_queue: got %0d pending, required 0", sb.size());
      end
   endtask

   task automatic test_reset_held();
      int c;
      bus.key_n_i[0] = 1'b0;
      rst_n = 1'b0;
      repeat (5) @(negedge clk);
      n_cmp++;
      if (bus.btn_level_o !== 4'h0) begin
         n_err++; $display("FAIL held_reset_level: got %h, required 0", bus.btn_level_o);
      end
      rst_n = 1'b1;
      c = cyc;
      // Synchronizer flops clear to 0, which already reads as pressed, so the
      // debounce count starts on the first edge after reset release.
      sb.push_back(mk(c + 10, 0, KIND_PRESS));
      repeat (9) @(negedge clk);
      n_cmp++;
      if (bus.btn_level_o[0] !== 1'b0) begin
         n_err++; $display("FAIL held_level_early: got %b, required 0", bus.btn_level_o[0]);
      end
      @(negedge clk);
      n_cmp++;
      if (bus.btn_level_o[0] !== 1'b1) begin
         n_err++; $display("FAIL held_level_set: got %b, required 1", bus.btn_level_o[0]);
      end
      bus.key_n_i[0] = 1'b1;
      sb.push_back(mk(c + 22, 0, KIND_RELEASE));
      repeat (16) @(negedge clk);
      n_cmp++;
      if (sb.size() !== 0) begin
         n_err++; $display("FAIL held_queue: got %0d pending, required 0", sb.size());
      end
   endtask

   task automatic test_simul_reset();
      int c;
      c = cyc;
      bus.key_n_i = 4'h0;
      for (int ch = 0; ch < 4; ch++) sb.push_back(mk(c + 12, ch, KIND_PRESS));
      repeat (12) @(negedge clk);
      n_cmp++;
      if (bus.press_o !== 4'hF) begin
         n_err++; $display("FAIL simul_press: got %h, required F", bus.press_o);
      end
      n_cmp++;
      if (bus.btn_level_o !== 4'hF) begin
         n_err++; $display("FAIL simul_level: got %h, required F", bus.btn_level_o);
      end
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      #1;
      n_cmp++;
      if ({bus.btn_level_o, bus.press_o, bus.release_o, bus.long_o, bus.repeat_o} !== 20'h0) begin
         n_err++; $display("FAIL simul_reset_outputs: got %h, required 00000",
                           {bus.btn_level_o, bus.press_o, bus.release_o, bus.long_o, bus.repeat_o});
      end
      bus.key_n_i = 4'hF;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (30) @(negedge clk);
      n_cmp++;
      if (bus.btn_level_o !== 4'h0) begin
         n_err++; $display("FAIL simul_after_level: got %h, required 0", bus.btn_level_o);
      end
      n_cmp++;
      if (sb.size() !== 0) begin
         n_err++; $display("FAIL simul_queue: got %0d pending, required 0", sb.size());
      end
   endtask

   initial begin
      rst_n = 1'b0;
      bus.key_n_i = 4'hF;
      fork
         monitor();
      join_none
      test_reset();
      test_press();
      test_glitch();
      test_long();
      test_repeat();
      test_reset_held();
      test_simul_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
